// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// uart_arb_pkg - shared state encoding and helpers for uart_tx_arbiter
// Revision: 1.0
// ------------------------------------------------------------------------
package uart_arb_pkg;

   localparam int BYTE_W  = 8;
   localparam int MAX_REQ = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOCK    = 3'd1,
      SEND    = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4,
      DONE    = 3'd5
   } arb_state_t;

   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (onehot[i]) begin
            idx = idx | 3'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// uart_tx_arbiter_if - requester and Serial-side signals of the arbiter
// Revision: 1.0
// ------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import uart_arb_pkg::*;

   logic [NUM_REQ-1:0]        i_req_valid;
   logic [BYTE_W*NUM_REQ-1:0] i_req_data;
   logic [NUM_REQ-1:0]        i_req_last;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic [NUM_REQ-1:0]        o_grant;
   logic                      i_txd_busy;
   logic                      o_send_to_computer;
   logic [BYTE_W-1:0]         o_tx_data;
   logic                      o_timeout;

   // Arbiter side
   modport master (
      input  i_req_valid, i_req_data, i_req_last, i_txd_busy,
      output o_req_ready, o_grant, o_send_to_computer, o_tx_data, o_timeout
   );

   // Requesters plus Serial transmitter side
   modport slave (
      output i_req_valid, i_req_data, i_req_last, i_txd_busy,
      input  o_req_ready, o_grant, o_send_to_computer, o_tx_data, o_timeout
   );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ------------------------------------------------------------------------
// rr_picker - combinational round-robin pick: first valid at/after ptr
// Revision: 1.0
// ------------------------------------------------------------------------
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  wire logic [NUM_REQ-1:0] valid,
   input  wire logic [IDX_W-1:0]   ptr,
   output logic      [NUM_REQ-1:0] grant,
   output logic      [IDX_W-1:0]   idx,
   output logic                    any
);

   logic [MAX_REQ-1:0] grant_ext;

   // Two passes: indices at/above the pointer first, then the wrapped part.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if ((grant == '0) && valid[i] && (i >= int'(ptr))) begin
            grant[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if ((grant == '0) && valid[i] && (i < int'(ptr))) begin
            grant[i] = 1'b1;
         end
      end
   end

   assign grant_ext = MAX_REQ'(grant);
   assign idx       = IDX_W'(onehot_to_idx(grant_ext));
   assign any       = |valid;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// uart_tx_arbiter - packet-locked round-robin sharing of one Serial UART TX.
// Optional UART_TX_ARB_STATS_EN adds o_tx_count. Revision: 1.0
// ------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int BUSY_TIMEOUT = 16
) (
   input  wire logic         i_Clk,
   input  wire logic         i_Rst_n,
   uart_tx_arbiter_if.master bus
`ifdef UART_TX_ARB_STATS_EN
   ,
   output logic [7:0]        o_tx_count
`endif
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    gnt_idx;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    rr_next;
   logic [CNT_W-1:0]    to_cnt;
   logic                last_flag;
   logic [BYTE_W-1:0]   tx_data;

   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;

   logic                gnt_valid;
   logic                gnt_last;
   logic [BYTE_W-1:0]   gnt_data;
   logic                accept;
   logic                to_hit;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid (bus.i_req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Owner's lane selected through the one-hot grant register.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      gnt_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            gnt_valid = bus.i_req_valid[k];
            gnt_last  = bus.i_req_last[k];
            gnt_data  = bus.i_req_data[k*BYTE_W +: BYTE_W];
         end
      end
   end

   assign accept  = (state == LOCK) && gnt_valid && !bus.i_txd_busy;
   assign to_hit  = (to_cnt == CNT_LAST);
   assign rr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = LOCK;
         LOCK:    if (accept) state_nxt = SEND;
         SEND:    state_nxt = WAIT_HI;
         WAIT_HI: begin
            if (bus.i_txd_busy) begin
               state_nxt = WAIT_LO;
            end else if (to_hit) begin
               state_nxt = DONE;
            end
         end
         WAIT_LO: if (!bus.i_txd_busy) state_nxt = DONE;
         DONE:    state_nxt = last_flag ? IDLE : LOCK;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant is held across the whole packet and only dropped in DONE on last.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         grant     <= '0;
         gnt_idx   <= '0;
         rr_ptr    <= '0;
         tx_data   <= '0;
         last_flag <= 1'b0;
         to_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant   <= pick_grant;
                  gnt_idx <= pick_idx;
               end
            end
            LOCK: begin
               if (accept) begin
                  tx_data   <= gnt_data;
                  last_flag <= gnt_last;
               end
            end
            SEND: to_cnt <= '0;
            WAIT_HI: begin
               if (!bus.i_txd_busy && !to_hit) begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (last_flag) begin
                  rr_ptr <= rr_next;
                  grant  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.o_req_ready        = '0;
      bus.o_send_to_computer = 1'b0;
      bus.o_timeout          = 1'b0;
      case (state)
         LOCK:    if (accept) bus.o_req_ready = grant;
         SEND:    bus.o_send_to_computer = 1'b1;
         WAIT_HI: bus.o_timeout = !bus.i_txd_busy && to_hit;
         default: ;
      endcase
   end

   assign bus.o_grant   = grant;
   assign bus.o_tx_data = tx_data;

`ifdef UART_TX_ARB_STATS_EN
   // A byte counts once Serial acknowledges it by raising busy.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_tx_count <= 8'd0;
      end else if ((state == WAIT_HI) && bus.i_txd_busy) begin
         o_tx_count <= o_tx_count + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_uart_tx_arbiter - vector table, directed corners and a randomized
// packet-level reference model for uart_tx_arbiter. Revision: 1.0
// ------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N  = 2;
   localparam int BT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef UART_TX_ARB_STATS_EN
   logic [7:0] tx_count;
`endif

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .BUSY_TIMEOUT (BT)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
`ifdef UART_TX_ARB_STATS_EN
      ,
      .o_tx_count (tx_count)
`endif
   );

   typedef struct packed {
      logic [35:0] p0;    // up to 4 entries {last,data}, entry 0 in low bits
      logic [2:0]  n0;
      logic [35:0] p1;
      logic [2:0]  n1;
      logic [7:0]  blen;
      logic [63:0] exp;   // expected strobe bytes, first in low byte
      logic [3:0]  nexp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [8:0] rq [N][$];
   bit         req_en [N];
   bit         busy_m, ext_busy, u_armed, drop_next, rand_delay;
   int         u_delay, u_left, busy_len, drop_pct;
   int         cyc, n_timeout, n_drop, n_ready, last_to_cyc;
   logic [7:0]   obs_data [$];
   logic [N-1:0] obs_grant [$];
   int           obs_cyc [$];
   logic [N-1:0] rdy_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         bus.i_req_valid[k] = req_en[k] && (rq[k].size() > 0);
         if (rq[k].size() > 0) begin
            bus.i_req_data[k*8 +: 8] = rq[k][0][7:0];
            bus.i_req_last[k]        = rq[k][0][8];
         end else begin
            bus.i_req_data[k*8 +: 8] = 8'h00;
            bus.i_req_last[k]        = 1'b0;
         end
      end
   endtask

   // One clock: Serial model and sampling at negedge, requester pops after posedge.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (u_left > 0) begin
         u_left--;
         if (u_left == 0) busy_m = 1'b0;
      end else if (u_armed) begin
         if (u_delay <= 1) begin
            busy_m  = 1'b1;
            u_left  = busy_len;
            u_armed = 1'b0;
         end else begin
            u_delay--;
         end
      end
      bus.i_txd_busy = busy_m | ext_busy;
      #1;
      rdy_s = bus.o_req_ready;
      if (rdy_s != '0) begin
         n_ready++;
         chk("ready_is_owner", 32'(rdy_s), 32'(bus.o_grant));
      end
      if (bus.o_timeout) begin
         n_timeout++;
         last_to_cyc = cyc;
      end
      if (bus.o_send_to_computer) begin
         obs_data.push_back(bus.o_tx_data);
         obs_grant.push_back(bus.o_grant);
         obs_cyc.push_back(cyc);
         u_armed = !(drop_next || ($urandom_range(99) < drop_pct));
         if (!u_armed) n_drop++;
         drop_next = 1'b0;
         u_delay   = rand_delay ? int'($urandom_range(3, 1)) : 1;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (rdy_s[k] && bus.i_req_valid[k] && (rq[k].size() > 0)) void'(rq[k].pop_front());
      end
      drive();
   endtask

   task automatic clear_obs();
      obs_data.delete();
      obs_grant.delete();
      obs_cyc.delete();
      n_timeout = 0;
      n_drop    = 0;
      n_ready   = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         rq[k].delete();
         req_en[k] = 1'b1;
      end
      busy_m = 0; ext_busy = 0; u_armed = 0; u_left = 0; u_delay = 0;
      drop_next = 0; drop_pct = 0; rand_delay = 0; busy_len = 3;
      bus.i_txd_busy = 1'b0;
      drive();
      step();
      step();
      rst_n = 1'b1;
      clear_obs();
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         step();
         done = !busy_m && !u_armed && (u_left == 0) && (bus.o_grant == '0);
         for (int k = 0; k < N; k++) if (rq[k].size() != 0) done = 1'b0;
      end
      chk({name, "_completes"}, 32'(done), 32'd1);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_grant"},   32'(bus.o_grant),            32'd0);
      chk({name, "_ready"},   32'(bus.o_req_ready),        32'd0);
      chk({name, "_send"},    32'(bus.o_send_to_computer), 32'd0);
      chk({name, "_txdata"},  32'(bus.o_tx_data),          32'd0);
      chk({name, "_timeout"}, 32'(bus.o_timeout),          32'd0);
   endtask

   vec_t vecs [5];

   initial begin
      vecs[0] = '{p0: 36'h141, n0: 3'd1, p1: 36'h0, n1: 3'd0, blen: 8'd20,
                  exp: 64'h41, nexp: 4'd1};
      vecs[1] = '{p0: {9'h0, 9'h10A, 9'h04B, 9'h04F}, n0: 3'd3, p1: 36'h158, n1: 3'd1,
                  blen: 8'd3, exp: {32'h0, 8'h58, 8'h0A, 8'h4B, 8'h4F}, nexp: 4'd4};
      vecs[2] = '{p0: {18'h0, 9'h111, 9'h111}, n0: 3'd2, p1: {18'h0, 9'h122, 9'h122}, n1: 3'd2,
                  blen: 8'd2, exp: {32'h0, 8'h22, 8'h11, 8'h22, 8'h11}, nexp: 4'd4};
      vecs[3] = '{p0: 36'h133, n0: 3'd1, p1: {18'h0, 9'h155, 9'h044}, n1: 3'd2,
                  blen: 8'd4, exp: {40'h0, 8'h55, 8'h44, 8'h33}, nexp: 4'd3};
      vecs[4] = '{p0: {9'h0, 9'h1B1, 9'h1A2, 9'h0A1}, n0: 3'd3, p1: {9'h0, 9'h1C3, 9'h0C2, 9'h0C1}, n1: 3'd3,
                  blen: 8'd1, exp: {16'h0, 8'hB1, 8'hC3, 8'hC2, 8'hC1, 8'hA2, 8'hA1}, nexp: 4'd6};

      bus.i_req_valid = '0; bus.i_req_data = '0; bus.i_req_last = '0; bus.i_txd_busy = 1'b0;
      cyc = 0;
      for (int k = 0; k < N; k++) req_en[k] = 1'b1;

      // Reset state
      rst_n = 1'b0;
      step();
      check_reset_outputs("reset");

      for (int v = 0; v < 5; v++) begin
         do_reset();
         busy_len = int'(vecs[v].blen);
         for (int i = 0; i < int'(vecs[v].n0); i++) rq[0].push_back(vecs[v].p0[9*i +: 9]);
         for (int i = 0; i < int'(vecs[v].n1); i++) rq[1].push_back(vecs[v].p1[9*i +: 9]);
         drive();
         wait_idle(600, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_strobes", v), 32'(obs_data.size()), 32'(vecs[v].nexp));
         chk($sformatf("vec%0d_ready_pulses", v), 32'(n_ready), 32'(vecs[v].nexp));
         for (int i = 0; i < int'(vecs[v].nexp) && i < obs_data.size(); i++)
            chk($sformatf("vec%0d_byte%0d", v, i), 32'(obs_data[i]), 32'(vecs[v].exp[8*i +: 8]));
         chk($sformatf("vec%0d_grant_idle", v), 32'(bus.o_grant), 32'd0);
      end

      // Latency from valid to strobe while idle and not busy
      begin
         int n;
         do_reset();
         rq[0].push_back({1'b1, 8'h3C});
         drive();
         n = 0;
         while (obs_data.size() == 0 && n < 10) begin
            step();
            n++;
         end
         chk("latency_cycles", 32'(n), 32'd3);
         wait_idle(100, "latency");
      end

      // Busy timeout on first byte; second byte still served
      do_reset();
      drop_next = 1'b1;
      rq[0].push_back({1'b1, 8'h77});
      rq[0].push_back({1'b1, 8'h78});
      drive();
      wait_idle(200, "timeout");
      chk("timeout_pulses", 32'(n_timeout), 32'd1);
      chk("timeout_strobes", 32'(obs_data.size()), 32'd2);
      if (obs_data.size() == 2) begin
         chk("timeout_byte0", 32'(obs_data[0]), 32'h77);
         chk("timeout_byte1", 32'(obs_data[1]), 32'h78);
         chk("timeout_delay", 32'(last_to_cyc - obs_cyc[0]), 32'(BT));
      end

      // Busy already high when requester 1 becomes valid
      do_reset();
      ext_busy = 1'b1;
      step();
      step();
      rq[1].push_back({1'b1, 8'h5A});
      drive();
      repeat (6) step();
      chk("busy_entry_no_ready", 32'(n_ready), 32'd0);
      chk("busy_entry_grant", 32'(bus.o_grant), 32'b10);
      ext_busy = 1'b0;
      step();
      chk("busy_exit_ready", 32'(n_ready), 32'd1);
      step();
      chk("busy_exit_strobe", 32'(obs_data.size()), 32'd1);
      if (obs_data.size() == 1) chk("busy_exit_byte", 32'(obs_data[0]), 32'h5A);
      wait_idle(100, "busy_entry");

      // Reset while waiting for busy to fall; pointer returns to 0
      do_reset();
      rq[0].push_back({1'b1, 8'h99});
      drive();
      wait_idle(100, "prereset");
      busy_len = 10;
      clear_obs();
      rq[0].push_back({1'b0, 8'h61});
      rq[0].push_back({1'b1, 8'h62});
      drive();
      for (int i = 0; i < 10 && obs_data.size() == 0; i++) step();
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      rq[1].push_back({1'b1, 8'h63});
      drive();
      step();
      step();
      clear_obs();
      rst_n = 1'b1;
      step();
      chk("postreset_grant", 32'(bus.o_grant), 32'b01);
      wait_idle(200, "postreset");
      chk("postreset_strobes", 32'(obs_data.size()), 32'd2);
      if (obs_data.size() == 2) begin
         chk("postreset_byte0", 32'(obs_data[0]), 32'h62);
         chk("postreset_byte1", 32'(obs_data[1]), 32'h63);
      end

      // Randomized packets against a packet-level round-robin model
      begin
         logic [7:0]   mq [N][$];
         int           ml [N][$];
         logic [7:0]   exp_b [$];
         logic [N-1:0] exp_g [$];
         int           m_ptr;
         do_reset();
         m_ptr = 0;
         for (int round = 0; round < 4; round++) begin
            clear_obs();
            exp_b.delete();
            exp_g.delete();
            drop_pct   = 12;
            rand_delay = 1'b1;
            busy_len   = int'($urandom_range(6, 1));
            for (int k = 0; k < N; k++) begin
               int np;
               np = int'($urandom_range(3, 0));
               for (int p = 0; p < np; p++) begin
                  int len;
                  len = int'($urandom_range(3, 1));
                  ml[k].push_back(len);
                  for (int b = 0; b < len; b++) begin
                     logic [7:0] d;
                     d = 8'($urandom);
                     mq[k].push_back(d);
                     rq[k].push_back({(b == len - 1), d});
                  end
               end
            end
            while (ml[0].size() + ml[1].size() > 0) begin
               int sel;
               int len;
               sel = -1;
               for (int j = 0; j < N; j++) begin
                  if (sel < 0 && ml[(m_ptr + j) % N].size() > 0) sel = (m_ptr + j) % N;
               end
               len = ml[sel].pop_front();
               for (int b = 0; b < len; b++) begin
                  exp_b.push_back(mq[sel].pop_front());
                  exp_g.push_back(N'(1) << sel);
               end
               m_ptr = (sel + 1) % N;
            end
            drive();
            wait_idle(3000, $sformatf("rand%0d", round));
            chk($sformatf("rand%0d_strobes", round), 32'(obs_data.size()), 32'(exp_b.size()));
            chk($sformatf("rand%0d_timeouts", round), 32'(n_timeout), 32'(n_drop));
            for (int i = 0; i < exp_b.size() && i < obs_data.size(); i++) begin
               chk($sformatf("rand%0d_byte%0d", round, i), 32'(obs_data[i]), 32'(exp_b[i]));
               chk($sformatf("rand%0d_owner%0d", round, i), 32'(obs_grant[i]), 32'(exp_g[i]));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single Serial UART transmitter between NUM_REQ byte-stream requesters, e.g. string_transmitter echo and a status reporter.
- Uses round-robin arbitration with packet locking: a grant is held until the requester's last byte.
- Sequences each byte into the Serial block. It presents the byte, pulses the send strobe, then tracks o_busy through its rise and fall before accepting the next byte.
- Sits between the requesters and Serial's i_send_data_to_host_computer / i_send_data / o_busy.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- BUSY_TIMEOUT, 16: cycles to wait for i_txd_busy to rise after a send strobe before abandoning the byte.

Ports:
- i_Clk  input  1  system clock (CLOCK_50).
- i_Rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester byte valid.
- i_req_data  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_req_last  input  NUM_REQ  byte is the last of its packet; qualified by valid.
- o_req_ready  output  NUM_REQ  byte accepted (one-hot, single-cycle).
- o_grant  output  NUM_REQ  one-hot current owner; zero when idle.
- i_txd_busy  input  1  Serial transmitter busy.
- o_send_to_computer  output  1  one-cycle send strobe to Serial.
- o_tx_data  output  8  byte to Serial; held stable from acceptance until the next acceptance.
- o_timeout  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_grant=0, o_req_ready=0, o_send_to_computer=0, o_tx_data=8'h00, o_timeout=0, rr pointer=0, timeout counter=0, last flag=0.
- A transfer occurs when i_req_valid[k] & o_req_ready[k]. Requesters hold data and last stable while valid is high.
- IDLE:
  - If any valid is set, pick the first set requester searching from rr pointer upward with wrap-around.
  - Set o_grant to that requester and go to LOCK. Decision takes 1 cycle.
  - If no valid is set, stay in IDLE.
- LOCK:
  - If the granted requester's valid=1 and i_txd_busy=0: assert its ready for this cycle, latch o_tx_data and the last flag, go to SEND.
  - Otherwise wait. A granted requester dropping valid mid-packet keeps the grant; there is no preemption.
- SEND: o_send_to_computer=1 for exactly one cycle; clear the timeout counter; go to WAIT_HI.
- WAIT_HI:
  - If i_txd_busy=1, go to WAIT_LO.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse o_timeout and proceed as if the byte completed (go to DONE).
- WAIT_LO: when i_txd_busy=0, go to DONE.
- DONE (1 cycle):
  - If the last flag is set: rr pointer = granted index + 1 (mod NUM_REQ), o_grant=0, go to IDLE.
  - Otherwise go to LOCK.
- Minimum spacing between send strobes is 4 cycles plus the UART busy time. Worst-case latency from valid to strobe, when idle and not busy, is 3 cycles (IDLE→LOCK→SEND).
- Simultaneous valid on all requesters: the rr pointer decides. After a packet ends, the next-higher index wins.
- Reset mid-transfer aborts immediately with no strobe. The Serial byte already in flight completes on its own.
- A last=1 byte from a requester is a single-byte packet.

Optional Feature:
- Macro UART_TX_ARB_STATS_EN.
- Defined: adds output o_tx_count [7:0]. It increments, wrapping 255→0, on each strobe whose byte does not time out, and is reset to 0. Intended for LEDR[7:0].
- Undefined: no port, no counter logic.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, LOCK, SEND, WAIT_HI, WAIT_LO, DONE), localparam BYTE_W=8, function onehot_to_idx.
- Sub-module rr_picker: combinational round-robin picker (valid vector + pointer → one-hot grant + index), parameterized by NUM_REQ.

Test Plan:
- Single byte: req0 sends 8'h41 with last=1, busy high for 20 cycles after the strobe.
  - ready0 pulses once, one strobe with o_tx_data=8'h41, grant returns to 0.
- Lock: req0 sends the packet "OK\n" (4F,4B,0A, last on 0A) while req1 holds valid with 8'h58.
  - Strobes carry 4F,4B,0A, then 58; no interleaving.
- Round-robin: both requesters continuously send single-byte packets (0x11 from req0, 0x22 from req1).
  - Strobe sequence 11,22,11,22.
- Timeout: strobe issued and busy held low for 16 cycles.
  - o_timeout pulses once, FSM reaches IDLE, next byte is still served.
- Busy at entry: busy=1 when req1 becomes valid.
  - ready1 is withheld until busy=0; then ready and strobe follow.
- Reset mid-WAIT_LO: assert i_Rst_n=0.
  - All outputs return to reset values asynchronously; after release, a pending req0 is granted first (pointer=0).
